// File: rtl/qcw_pkg.sv
// Purpose: shared constants for the QCW ramp sequencer (register offsets, state encoding, STATUS bits).
// Latency: none; constants and one combinational helper.
// Backpressure: none.
package qcw_pkg;

  // Size of the register window in bytes: six 32-bit words.
  localparam int unsigned QCW_WINDOW_BYTES = 24;

  // Byte offsets within the window. The OCD block uses the same offset-constant style.
  localparam logic [4:0] OFF_START_LVL = 5'd0;
  localparam logic [4:0] OFF_END_LVL   = 5'd4;
  localparam logic [4:0] OFF_STEP_PER  = 5'd8;
  localparam logic [4:0] OFF_HOLD_CYC  = 5'd12;
  localparam logic [4:0] OFF_CONTROL   = 5'd16;
  localparam logic [4:0] OFF_STATUS    = 5'd20;

  // CONTROL bits.
  localparam int CTRL_FIRE_BIT  = 0;
  localparam int CTRL_ABORT_BIT = 1;

  // STATUS layout: {26'b0, cfg_err, halted, state[1:0], busy, qcw_halt}.
  localparam int STS_QCW_HALT_BIT = 0;
  localparam int STS_BUSY_BIT     = 1;
  localparam int STS_STATE_LSB    = 2;
  localparam int STS_HALTED_BIT   = 4;
  localparam int STS_CFG_ERR_BIT  = 5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RAMP     = 2'd1,
    ST_HOLD     = 2'd2,
    ST_COOLDOWN = 2'd3
  } qcw_state_e;

  // Replace only the strobed bytes of the current register contents.
  function automatic logic [31:0] merge_wstrb(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = wstrb[b] ? wdata[b*8 +: 8] : cur[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/qcw_bus_regs.sv
// Purpose: CPU-bus register window for the QCW sequencer: decode, ready edge-detect, config and shadow regs.
// Latency: ready and read data are combinational on the first addressed cycle; writes land on the next edge.
// Backpressure: none; every addressed request is acknowledged on its first cycle, held requests get no second ack.
// Ports: mem_* native CPU bus; status_word = live STATUS contents from the sequencer;
//        shadow_load copies config into the shadow set; cfg_start_lvl/cfg_end_lvl are the live
//        values used at fire time; sh_* are the shadow values for the running pulse;
//        fire/abort/status_clr are one-cycle write strobes.
module qcw_bus_regs
  import qcw_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid_i,
  output logic        mem_ready_o,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_wstrb_i,
  output logic [31:0] mem_rdata_o,
  input  logic [31:0] status_word,
  input  logic        shadow_load,
  output logic [9:0]  cfg_start_lvl,
  output logic [9:0]  cfg_end_lvl,
  output logic [9:0]  sh_end_lvl,
  output logic [15:0] sh_step_per,
  output logic [23:0] sh_hold_cyc,
  output logic        fire,
  output logic        abort,
  output logic        status_clr
);

  logic [31:0] off;
  logic        addressed, addressed_q, req, wr, ctrl_wr;
  logic [15:0] cfg_step_per;
  logic [23:0] cfg_hold_cyc;
  logic [31:0] reg_word, wr_word;
  logic        unused_wr_hi;

  // Unsigned wrap makes addresses below BASE_ADDR land far outside the window.
  assign off       = mem_addr_i - BASE_ADDR;
  assign addressed = mem_valid_i && (off < QCW_WINDOW_BYTES);

  always_ff @(posedge clk) begin
    if (reset) addressed_q <= 1'b0;
    else       addressed_q <= addressed;
  end

  // Only the first cycle of a held request is acknowledged.
  assign req         = addressed && !addressed_q;
  assign wr          = req && (mem_wstrb_i != 4'b0000);
  assign mem_ready_o = req;

  always_comb begin
    reg_word = '0;
    case (off[4:0])
      OFF_START_LVL: reg_word = {22'b0, cfg_start_lvl};
      OFF_END_LVL:   reg_word = {22'b0, cfg_end_lvl};
      OFF_STEP_PER:  reg_word = {16'b0, cfg_step_per};
      OFF_HOLD_CYC:  reg_word = {8'b0, cfg_hold_cyc};
      OFF_STATUS:    reg_word = status_word;
      default:       reg_word = '0;
    endcase
  end

  assign mem_rdata_o = req ? reg_word : '0;

  assign wr_word = merge_wstrb(reg_word, mem_wdata_i, mem_wstrb_i);
  // No register is wider than 24 bits; the top byte of a merged write is dropped.
  assign unused_wr_hi = ^wr_word[31:24];

  // Abort has priority over fire when both bits arrive in one write.
  assign ctrl_wr    = wr && (off[4:0] == OFF_CONTROL) && mem_wstrb_i[0];
  assign fire       = ctrl_wr && mem_wdata_i[CTRL_FIRE_BIT] && !mem_wdata_i[CTRL_ABORT_BIT];
  assign abort      = ctrl_wr && mem_wdata_i[CTRL_ABORT_BIT];
  assign status_clr = wr && (off[4:0] == OFF_STATUS);

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_start_lvl <= '0;
      cfg_end_lvl   <= '0;
      cfg_step_per  <= '0;
      cfg_hold_cyc  <= '0;
      sh_end_lvl    <= '0;
      sh_step_per   <= '0;
      sh_hold_cyc   <= '0;
    end else begin
      if (wr) begin
        case (off[4:0])
          OFF_START_LVL: cfg_start_lvl <= wr_word[9:0];
          OFF_END_LVL:   cfg_end_lvl   <= wr_word[9:0];
          OFF_STEP_PER:  cfg_step_per  <= wr_word[15:0];
          OFF_HOLD_CYC:  cfg_hold_cyc  <= wr_word[23:0];
          default: ;
        endcase
      end
      // Config writes and fire are different addresses, so the copy never races a config update.
      if (shadow_load) begin
        sh_end_lvl  <= cfg_end_lvl;
        sh_step_per <= cfg_step_per;
        sh_hold_cyc <= cfg_hold_cyc;
      end
    end
  end

endmodule

// File: rtl/qcw_ramp_sequencer.sv
// Purpose: one QCW pulse per fire: linear power ramp START->END, hold, then enforced cooldown.
// Latency: fire write -> qcw_start/qcw_enable next cycle; qcw_halt -> qcw_enable low next cycle.
// Backpressure: none; fire while busy is dropped, bus is acked by qcw_bus_regs.
// Ports: clk, reset (sync, active-high); mem_* CPU bus; qcw_halt OCD trip (level);
//        qcw_start one-cycle pulse on RAMP entry; qcw_enable high in RAMP/HOLD;
//        power_level commanded bridge level, 0 whenever qcw_enable is low.
module qcw_ramp_sequencer
  import qcw_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned COOLDOWN_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid_i,
  output logic        mem_ready_o,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_wstrb_i,
  output logic [31:0] mem_rdata_o,
  input  logic        qcw_halt,
  output logic        qcw_start,
  output logic        qcw_enable,
  output logic [9:0]  power_level
);

  localparam int unsigned CD_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam logic [CD_W-1:0] CD_LAST = CD_W'((COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0);

  qcw_state_e  state_q, state_nx;
  logic [9:0]  cfg_start_lvl, cfg_end_lvl, sh_end_lvl, level_q;
  logic [15:0] sh_step_per, step_last, step_cnt;
  logic [23:0] sh_hold_cyc, hold_cnt;
  logic [CD_W-1:0] cd_cnt;
  logic        fire, abort, status_clr, enter_ramp;
  logic        start_q, halted_q, cfg_err_q, set_halted, set_cfg_err;
  logic [31:0] status_word;

  assign status_word = {26'b0, cfg_err_q, halted_q, state_q, (state_q != ST_IDLE), qcw_halt};

  qcw_bus_regs #(.BASE_ADDR(BASE_ADDR)) u_regs (
    .clk          (clk),
    .reset        (reset),
    .mem_valid_i  (mem_valid_i),
    .mem_ready_o  (mem_ready_o),
    .mem_addr_i   (mem_addr_i),
    .mem_wdata_i  (mem_wdata_i),
    .mem_wstrb_i  (mem_wstrb_i),
    .mem_rdata_o  (mem_rdata_o),
    .status_word  (status_word),
    .shadow_load  (enter_ramp),
    .cfg_start_lvl(cfg_start_lvl),
    .cfg_end_lvl  (cfg_end_lvl),
    .sh_end_lvl   (sh_end_lvl),
    .sh_step_per  (sh_step_per),
    .sh_hold_cyc  (sh_hold_cyc),
    .fire         (fire),
    .abort        (abort),
    .status_clr   (status_clr)
  );

  // STEP_PER of 0 behaves as 1.
  assign step_last  = (sh_step_per == 16'd0) ? 16'd0 : sh_step_per - 16'd1;
  assign enter_ramp = (state_q == ST_IDLE) && (state_nx == ST_RAMP);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_nx;
  end

  // qcw_halt is checked first so it beats level steps, HOLD expiry and software abort.
  always_comb begin
    state_nx    = state_q;
    set_halted  = 1'b0;
    set_cfg_err = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (fire) begin
          if (qcw_halt)                         set_halted  = 1'b1;
          else if (cfg_start_lvl > cfg_end_lvl) set_cfg_err = 1'b1;
          else                                  state_nx    = ST_RAMP;
        end
      end
      ST_RAMP, ST_HOLD: begin
        if (qcw_halt) begin
          state_nx   = ST_COOLDOWN;
          set_halted = 1'b1;
        end else if (abort) begin
          state_nx = ST_COOLDOWN;
        end else if (state_q == ST_RAMP) begin
          if (level_q == sh_end_lvl) state_nx = ST_HOLD;
        end else if (hold_cnt <= 24'd1) begin
          state_nx = ST_COOLDOWN;
        end
      end
      ST_COOLDOWN: begin
        if (cd_cnt >= CD_LAST) state_nx = ST_IDLE;
      end
    endcase
  end

  // Outputs decode registered state only, so they change one edge after the cause.
  always_comb begin
    qcw_enable  = (state_q == ST_RAMP) || (state_q == ST_HOLD);
    qcw_start   = start_q;
    power_level = qcw_enable ? level_q : 10'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_q   <= 1'b0;
      level_q   <= '0;
      step_cnt  <= '0;
      hold_cnt  <= '0;
      cd_cnt    <= '0;
      halted_q  <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      start_q <= enter_ramp;

      if (enter_ramp) begin
        level_q  <= cfg_start_lvl;
        step_cnt <= '0;
      end else if ((state_q == ST_RAMP) && (state_nx == ST_RAMP)) begin
        // Staying in RAMP implies level_q < END, so the increment cannot overshoot.
        if (step_cnt >= step_last) begin
          step_cnt <= '0;
          level_q  <= level_q + 10'd1;
        end else begin
          step_cnt <= step_cnt + 16'd1;
        end
      end

      if ((state_q == ST_RAMP) && (state_nx == ST_HOLD)) hold_cnt <= sh_hold_cyc;
      else if (state_q == ST_HOLD)                        hold_cnt <= hold_cnt - 24'd1;

      if ((state_nx == ST_COOLDOWN) && (state_q != ST_COOLDOWN)) cd_cnt <= '0;
      else if (state_q == ST_COOLDOWN)                          cd_cnt <= cd_cnt + 1'b1;

      // A trip in the same cycle as a STATUS write leaves the flag set.
      if (set_halted)      halted_q <= 1'b1;
      else if (status_clr) halted_q <= 1'b0;
      if (set_cfg_err)     cfg_err_q <= 1'b1;
      else if (status_clr) cfg_err_q <= 1'b0;
    end
  end

endmodule
